// File: rtl/fft_input_loader_if.sv
// Handshake and memory-load signal bundle for fft_input_loader.
// The master modport is the loader itself; slave is the surrounding system.
interface fft_input_loader_if #(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 64
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              mem_we;
  logic [N_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              start_fft;
  logic              fft_done;
  logic              busy;
  logic              frame_err;

  modport master (
    input  s_valid, s_data, s_last, fft_done,
    output s_ready, mem_we, mem_addr, mem_din, start_fft, busy, frame_err
  );

  modport slave (
    output s_valid, s_data, s_last, fft_done,
    input  s_ready, mem_we, mem_addr, mem_din, start_fft, busy, frame_err
  );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one N-sample frame into the FFT memory in bit-reversed order, then starts the FFT.
// Optional FFT_LOADER_PRESCALE_EN: arithmetic right-shift of re/im by PRESHIFT before storing.
module fft_input_loader #(
  parameter int N_LOG2   = 5,
  parameter int DATA_W   = 64,
  parameter int PRESHIFT = 1
) (
  input logic                 clk,
  input logic                 rst,
  fft_input_loader_if.master  bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [N_LOG2-1:0] CNT_MAX = {N_LOG2{1'b1}};

  state_t              state_r;
  logic [N_LOG2-1:0]   cnt_r;
  logic                s_ready_r;
  logic                mem_we_r;
  logic [N_LOG2-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_din_r;
  logic                start_fft_r;
  logic                busy_r;
  logic                frame_err_r;
  logic                xfer_s;
  logic                last_beat_s;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  // Sign-extending shift keeps each half in two's complement, rounding toward -inf.
  function automatic logic [DATA_W-1:0] prescale(input logic [DATA_W-1:0] d);
    logic signed [DATA_W/2-1:0] re_v;
    logic signed [DATA_W/2-1:0] im_v;
    re_v = d[DATA_W-1:DATA_W/2];
    im_v = d[DATA_W/2-1:0];
    return {re_v >>> PRESHIFT, im_v >>> PRESHIFT};
  endfunction

  assign xfer_s      = bus.s_valid && s_ready_r && (state_r == LOAD);
  assign last_beat_s = (cnt_r == CNT_MAX);

  // Frame sequencing FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= LOAD;
      cnt_r       <= '0;
      s_ready_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_din_r   <= '0;
      start_fft_r <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      mem_we_r    <= 1'b0;
      start_fft_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (xfer_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= bitrev(cnt_r);
`ifdef FFT_LOADER_PRESCALE_EN
            mem_din_r   <= prescale(bus.s_data);
`else
            mem_din_r   <= bus.s_data;
`endif
            busy_r      <= 1'b1;
            // s_last only flags misalignment; the frame length is fixed.
            frame_err_r <= bus.s_last ^ last_beat_s;
            if (last_beat_s) begin
              cnt_r       <= '0;
              state_r     <= START;
              start_fft_r <= 1'b1;
              s_ready_r   <= 1'b0;
            end else begin
              cnt_r       <= cnt_r + N_LOG2'(1);
              s_ready_r   <= 1'b1;
            end
          end else begin
            s_ready_r <= 1'b1;
          end
        end
        START: begin
          state_r   <= WAIT;
          s_ready_r <= 1'b0;
        end
        WAIT: begin
          if (bus.fft_done) begin
            state_r   <= LOAD;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            s_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= LOAD;
          cnt_r     <= '0;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_din   = mem_din_r;
  assign bus.start_fft = start_fft_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed, table-driven bench for fft_input_loader (32-point frames).
// Define FFT_LOADER_PRESCALE_EN for both files to exercise the prescale build.
module tb_fft_input_loader;

  logic clk;
  logic rst;

  fft_input_loader_if #(.N_LOG2(5), .DATA_W(64)) bus ();

  fft_input_loader #(.N_LOG2(5), .DATA_W(64), .PRESHIFT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic        last;
    logic        done;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] din;
    logic        start;
    logic        ready;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t        vec [0:255];
  int          nvec;
  int          tests_run;
  int          tests_failed;
  logic [4:0]  addr_tab [0:31];

  localparam logic [63:0] SPECIAL_IN = 64'h8000_0000_0000_0003;
`ifdef FFT_LOADER_PRESCALE_EN
  localparam logic [63:0] SPECIAL_EXP = 64'hC000_0000_0000_0001;
`else
  localparam logic [63:0] SPECIAL_EXP = 64'h8000_0000_0000_0003;
`endif

  // Expected stored word for ordinary samples (shift by one when prescaling).
  function automatic logic [63:0] exp_din(input logic [63:0] d);
`ifdef FFT_LOADER_PRESCALE_EN
    return {d[63], d[63:33], d[31], d[31:1]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic add_rec(input logic valid, input logic [63:0] data, input logic last, input logic done,
                         input logic we, input logic [4:0] addr, input logic [63:0] din,
                         input logic start, input logic ready, input logic busy, input logic err);
    vec[nvec] = '{valid, data, last, done, we, addr, din, start, ready, busy, err};
    nvec++;
  endtask

  // One 32-beat frame; optional idle gaps (with fft_done asserted, which LOAD must ignore).
  task automatic add_frame(input bit toggle, input int bad_last_beat, input bit drop_last, input bit special0);
    logic [63:0] d;
    logic [63:0] e;
    logic        l;
    logic        er;
    for (int i = 0; i < 32; i++) begin
      d  = {i[31:0], 32'h0000_0000};
      e  = exp_din(d);
      if (special0 && i == 0) begin
        d = SPECIAL_IN;
        e = SPECIAL_EXP;
      end
      l  = ((i == 31) && !drop_last) || (i == bad_last_beat);
      er = (i == bad_last_beat) || ((i == 31) && drop_last);
      add_rec(1'b1, d, l, 1'b0, 1'b1, addr_tab[i], e, (i == 31), (i != 31), 1'b1, er);
      if (toggle && i != 31)
        add_rec(1'b0, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  // START cycle (fft_done there is ignored), n-1 WAIT cycles with s_valid high, then fft_done.
  task automatic add_wait(input int n);
    add_rec(1'b1, 64'h1111_1111_2222_2222, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < n; i++)
      add_rec(1'b1, 64'h3333_3333_4444_4444, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_rec(1'b1, 64'h5555_5555_6666_6666, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_rec(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Drive each record at a falling edge, check outputs one falling edge later.
  task automatic run_table();
    for (int i = 0; i < nvec; i++) begin
      bus.s_valid  = vec[i].valid;
      bus.s_data   = vec[i].data;
      bus.s_last   = vec[i].last;
      bus.fft_done = vec[i].done;
      @(negedge clk);
      chk("mem_we",    i, 64'(bus.mem_we),    64'(vec[i].we));
      chk("start_fft", i, 64'(bus.start_fft), 64'(vec[i].start));
      chk("s_ready",   i, 64'(bus.s_ready),   64'(vec[i].ready));
      chk("busy",      i, 64'(bus.busy),      64'(vec[i].busy));
      chk("frame_err", i, 64'(bus.frame_err), 64'(vec[i].err));
      if (vec[i].we) begin
        chk("mem_addr", i, 64'(bus.mem_addr), 64'(vec[i].addr));
        chk("mem_din",  i, bus.mem_din,       vec[i].din);
      end
    end
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.fft_done = 1'b0;
  endtask

  task automatic chk_all_zero(input int tag);
    chk("rst_s_ready",   tag, 64'(bus.s_ready),   64'd0);
    chk("rst_mem_we",    tag, 64'(bus.mem_we),    64'd0);
    chk("rst_mem_addr",  tag, 64'(bus.mem_addr),  64'd0);
    chk("rst_mem_din",   tag, bus.mem_din,        64'd0);
    chk("rst_start_fft", tag, 64'(bus.start_fft), 64'd0);
    chk("rst_busy",      tag, 64'(bus.busy),      64'd0);
    chk("rst_frame_err", tag, 64'(bus.frame_err), 64'd0);
  endtask

  initial begin
    addr_tab = '{5'd0, 5'd16, 5'd8, 5'd24, 5'd4, 5'd20, 5'd12, 5'd28,
                 5'd2, 5'd18, 5'd10, 5'd26, 5'd6, 5'd22, 5'd14, 5'd30,
                 5'd1, 5'd17, 5'd9, 5'd25, 5'd5, 5'd21, 5'd13, 5'd29,
                 5'd3, 5'd19, 5'd11, 5'd27, 5'd7, 5'd23, 5'd15, 5'd31};
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = 64'd0;
    bus.s_last   = 1'b0;
    bus.fft_done = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk_all_zero(0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 64'(bus.s_ready), 64'd1);

    // Plain frame + long WAIT; toggled frame; misaligned s_last frame with prescale sample.
    nvec = 0;
    add_frame(1'b0, -1, 1'b0, 1'b0);
    add_wait(20);
    add_frame(1'b1, -1, 1'b0, 1'b0);
    add_wait(3);
    add_frame(1'b0, 10, 1'b1, 1'b1);
    add_wait(2);
    run_table();

    // Partial frame of 13 beats, then asynchronous reset mid-frame.
    for (int i = 0; i < 13; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = {32'hABCD_0000 + 32'(i), 32'h0000_0001};
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk("pre_rst_busy", 1, 64'(bus.busy),     64'd1);
    chk("pre_rst_we",   1, 64'(bus.mem_we),   64'd1);
    chk("pre_rst_addr", 1, 64'(bus.mem_addr), 64'd6);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero(1);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero(2);
    rst = 1'b0;
    @(negedge clk);

    // Fresh frame must start at address 0 and give exactly one start pulse.
    nvec = 0;
    add_frame(1'b0, -1, 1'b0, 1'b0);
    add_wait(2);
    run_table();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
